onehot_sequencer: RTL and testbench
===================================

ONEHOT_SEQUENCER -- requirements
Module: onehot_sequencer

Interface
REQ-001 Parameter NSTEPS, default 9: number of one-hot steps; legal range 2..64.
REQ-002 Parameter LOOP_START, default 1: index re-entered on wrap; legal range 0..NSTEPS-1.
REQ-003 Derived constant IW = max(1, ceil(log2(NSTEPS))): width of index ports.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  advance one step this cycle.
REQ-007 dir  input  1  0 = forward (index+1), 1 = reverse (index-1); ignored in ping-pong mode.
REQ-008 mode  input  2  00 cycle, 01 one-shot, 10 ping-pong, 11 treated as 00.
REQ-009 load  input  1  jump to load_idx this cycle.
REQ-010 load_idx  input  IW  target index for load.
REQ-011 step  output  NSTEPS  registered one-hot step vector.
REQ-012 idx  output  IW  registered binary index of the set bit in step.
REQ-013 wrap  output  1  registered one-cycle pulse on wrap or bounce.
REQ-014 done  output  1  registered level, one-shot terminal reached.
REQ-015 err  output  1  registered sticky error flag.

Function
REQ-016 Priority per cycle SHALL be: rst > illegal-state recovery > load > en > hold.
REQ-017 With en=0 and load=0, step, idx, done SHALL hold; wrap SHALL be 0.
REQ-018 Cycle forward: idx k -> k+1; idx NSTEPS-1 -> LOOP_START with wrap=1.
REQ-019 Cycle reverse: idx k -> k-1 for k > LOOP_START; idx <= LOOP_START -> NSTEPS-1 with wrap=1.
REQ-020 Indices below LOOP_START SHALL be reachable only via reset or load; forward from them advances normally.
REQ-021 One-shot forward SHALL stop at NSTEPS-1; reverse SHALL stop at 0; done SHALL rise in the same cycle step reaches the terminal; no wrap pulse.
REQ-022 While done=1, en SHALL be ignored; done SHALL clear only on accepted load or rst.
REQ-023 Ping-pong: internal direction flag (reset = forward) SHALL advance idx; at NSTEPS-1 moving forward, or LOOP_START moving reverse, the flag SHALL toggle and idx SHALL move one step the other way, wrap=1 in that cycle.
REQ-024 Ping-pong with NSTEPS-1 = LOOP_START SHALL hold idx and pulse wrap on every en cycle.
REQ-025 Ping-pong from idx < LOOP_START SHALL force flag forward and step forward.
REQ-026 wrap SHALL be high exactly in the cycle step first shows the post-wrap/bounce value.
REQ-027 Accepted load (load_idx < NSTEPS) SHALL set idx = load_idx, step = one-hot(load_idx) next cycle, clear done, wrap=0; ping-pong flag unchanged.
REQ-028 Load with load_idx >= NSTEPS SHALL leave state unchanged and set err.
REQ-029 mode or dir changes SHALL take effect on the next en cycle with no extra latency; leaving one-shot SHALL not clear done.
REQ-030 If step is not exactly one-hot or disagrees with idx, next cycle SHALL force step = one-hot(0), idx = 0, done = 0, set err.
REQ-031 Latency from en/load to step/idx change SHALL be one cycle; step and idx SHALL always change together.

Reset
REQ-032 On rst: step = one-hot(0), idx = 0, wrap = 0, done = 0, err = 0, ping-pong flag = forward.
REQ-033 rst mid-sequence SHALL override load/en in the same cycle; err cleared only by rst.

Structure
REQ-034 Shared package stepper_pkg SHALL hold the mode encodings (MODE_CYCLE, MODE_ONESHOT, MODE_PINGPONG) and the index-width function.
REQ-035 One sub-module onehot_check SHALL compute one-hot validity and binary encoding of step; sequencing logic stays in onehot_sequencer.

Verification (NSTEPS=9, LOOP_START=1 unless stated)
REQ-036 rst, then en=1 mode=00 dir=0 for 10 cycles -> idx 0,1..8,1; wrap=1 only when idx becomes 1 after 8; step=9'h002 then.
REQ-037 mode=00 dir=1 from idx 0 -> idx 8 with wrap=1, then 7..1, then 8 with wrap=1.
REQ-038 mode=01 dir=0 from load 5 -> 6,7,8, done=1 at 8, further en holds 8; load 2 -> idx 2, done=0.
REQ-039 mode=10 from idx 0 for 20 en cycles -> 1..8,7 (wrap at 7),..,1,2 (wrap at 2); dir toggled randomly has no effect.
REQ-040 load=1 load_idx=12 with en=1 -> state holds, err=1 sticky; simultaneous load=1 load_idx=3 and en=1 -> idx 3.
REQ-041 Forced step=9'h006 (corruption) -> next cycle step=9'h001, idx=0, err=1; rst mid-run -> step=9'h001, err=0.

Source files
------------

// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stepper_pkg
// Description : Mode encodings and index-width helper for the one-hot stepper
// Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

    localparam logic [1:0] MODE_CYCLE    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    // Width of a binary index able to address n steps, never below one bit.
    function automatic int calc_iw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_check.sv
`default_nettype none
// ============================================================================
// Module      : onehot_check
// Description : One-hot validity test and binary encoding of a step vector
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_check
    import stepper_pkg::*;
#(
    parameter int NSTEPS = 9,
    parameter int IW     = calc_iw(NSTEPS)
) (
    input  logic [NSTEPS-1:0] step,
    output logic              valid,
    output logic [IW-1:0]     enc
);

    always_comb begin
        valid = ($countones(step) == 1);
        enc   = '0;
        for (int i = 0; i < NSTEPS; i++) begin
            if (step[i]) begin
                enc = enc | IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/onehot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : onehot_sequencer
// Description : One-hot step sequencer with cycle, one-shot and ping-pong modes
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_sequencer
    import stepper_pkg::*;
#(
    parameter  int NSTEPS     = 9,
    parameter  int LOOP_START = 1,
    localparam int IW         = calc_iw(NSTEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [IW-1:0]     load_idx,
    output logic [NSTEPS-1:0] step,
    output logic [IW-1:0]     idx,
    output logic              wrap,
    output logic              done,
    output logic              err
);

    localparam logic [IW-1:0]     c_last     = IW'(NSTEPS - 1);
    localparam logic [IW-1:0]     c_loop     = IW'(LOOP_START);
    localparam logic [IW-1:0]     c_one      = IW'(1);
    localparam logic [IW:0]       c_nsteps   = (IW + 1)'(NSTEPS);
    localparam logic [NSTEPS-1:0] c_step_rst = NSTEPS'(1);

    logic [NSTEPS-1:0] r_step;
    logic [IW-1:0]     r_idx;
    logic              r_wrap;
    logic              r_done;
    logic              r_err;
    logic              r_rev;

    logic [NSTEPS-1:0] w_step_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic              w_wrap_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_rev_nxt;
    logic              w_valid;
    logic [IW-1:0]     w_enc;
    logic              w_bad;
    logic              w_load_ok;

    onehot_check #(
        .NSTEPS (NSTEPS),
        .IW     (IW)
    ) u_check (
        .step  (r_step),
        .valid (w_valid),
        .enc   (w_enc)
    );

    assign w_bad     = !w_valid || (w_enc != r_idx);
    assign w_load_ok = ({1'b0, load_idx} < c_nsteps);

    always_comb begin
        w_idx_nxt  = r_idx;
        w_wrap_nxt = 1'b0;
        w_done_nxt = r_done;
        w_err_nxt  = r_err;
        w_rev_nxt  = r_rev;
        if (w_bad) begin
            w_idx_nxt  = '0;
            w_done_nxt = 1'b0;
            w_err_nxt  = 1'b1;
        end else if (load) begin
            if (w_load_ok) begin
                w_idx_nxt  = load_idx;
                w_done_nxt = 1'b0;
            end else begin
                w_err_nxt  = 1'b1;
            end
        end else if (en && !r_done) begin
            case (mode)
                MODE_ONESHOT: begin
                    if (!dir) begin
                        if (r_idx != c_last) w_idx_nxt = r_idx + c_one;
                        w_done_nxt = (w_idx_nxt == c_last);
                    end else begin
                        if (r_idx != '0) w_idx_nxt = r_idx - c_one;
                        w_done_nxt = (w_idx_nxt == '0);
                    end
                end
                MODE_PINGPONG: begin
                    // Below the loop region the sequence always climbs back in forward.
                    if (r_idx < c_loop) begin
                        w_rev_nxt = 1'b0;
                        w_idx_nxt = r_idx + c_one;
                    end else if (c_last == c_loop) begin
                        w_wrap_nxt = 1'b1;
                    end else if (!r_rev) begin
                        if (r_idx == c_last) begin
                            w_rev_nxt  = 1'b1;
                            w_idx_nxt  = r_idx - c_one;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_idx_nxt  = r_idx + c_one;
                        end
                    end else begin
                        if (r_idx == c_loop) begin
                            w_rev_nxt  = 1'b0;
                            w_idx_nxt  = r_idx + c_one;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_idx_nxt  = r_idx - c_one;
                        end
                    end
                end
                default: begin
                    if (!dir) begin
                        if (r_idx == c_last) begin
                            w_idx_nxt  = c_loop;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_idx_nxt  = r_idx + c_one;
                        end
                    end else begin
                        if (r_idx <= c_loop) begin
                            w_idx_nxt  = c_last;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_idx_nxt  = r_idx - c_one;
                        end
                    end
                end
            endcase
        end
        // Step is always rebuilt from the index so the two can never diverge.
        w_step_nxt = c_step_rst << w_idx_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step <= c_step_rst;
            r_idx  <= '0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_rev  <= 1'b0;
        end else begin
            r_step <= w_step_nxt;
            r_idx  <= w_idx_nxt;
            r_wrap <= w_wrap_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            r_rev  <= w_rev_nxt;
        end
    end

    assign step = r_step;
    assign idx  = r_idx;
    assign wrap = r_wrap;
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_onehot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_sequencer
// Description : Self-checking bench: vector table, corruption cases, random model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_sequencer;

    localparam int N  = 9;
    localparam int LS = 1;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          dir;
    logic [1:0]    mode;
    logic          load;
    logic [IW-1:0] load_idx;
    logic [N-1:0]  step;
    logic [IW-1:0] idx;
    logic          wrap;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    onehot_sequencer #(
        .NSTEPS     (N),
        .LOOP_START (LS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_idx (load_idx),
        .step     (step),
        .idx      (idx),
        .wrap     (wrap),
        .done     (done),
        .err      (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit       rst, en, dir, load;
        bit [1:0] mode;
        bit [3:0] li;
        int       eidx;
        bit       ewrap, edone, eerr;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int m_idx, m_done, m_err, m_rev, m_wrap;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic add(input bit r, input bit e, input bit d, input bit [1:0] m,
                       input bit l, input bit [3:0] li, input int ei,
                       input bit ew, input bit ed, input bit ee);
        vec_t v;
        v.rst = r; v.en = e; v.dir = d; v.mode = m; v.load = l; v.li = li;
        v.eidx = ei; v.ewrap = ew; v.edone = ed; v.eerr = ee;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit r, input bit e, input bit d, input bit [1:0] m,
                         input bit l, input bit [3:0] li);
        @(negedge clk);
        rst = r; en = e; dir = d; mode = m; load = l; load_idx = li;
    endtask

    task automatic cmp_all(input string tag, input int ei, input bit ew,
                           input bit ed, input bit ee);
        bit [N-1:0] es;
        es = N'(1) << ei;
        chk({tag, ".idx"},  int'(idx),  ei);
        chk({tag, ".step"}, int'(step), int'(es));
        chk({tag, ".wrap"}, int'(wrap), int'(ew));
        chk({tag, ".done"}, int'(done), int'(ed));
        chk({tag, ".err"},  int'(err),  int'(ee));
    endtask

    // Behavioural model: moves are attempted and reflected when they leave the range.
    task automatic model(input bit r, input bit e, input bit d, input bit [1:0] m,
                         input bit l, input int li);
        int md, tgt, nxt;
        m_wrap = 0;
        if (r) begin
            m_idx = 0; m_done = 0; m_err = 0; m_rev = 0;
        end else if (l) begin
            if (li < N) begin
                m_idx = li; m_done = 0;
            end else begin
                m_err = 1;
            end
        end else if (e && m_done == 0) begin
            md = (m == 2'd3) ? 0 : int'(m);
            if (md == 0) begin
                if (!d) begin
                    if (m_idx == N - 1) begin m_idx = LS; m_wrap = 1; end
                    else m_idx = m_idx + 1;
                end else begin
                    if (m_idx <= LS) begin m_idx = N - 1; m_wrap = 1; end
                    else m_idx = m_idx - 1;
                end
            end else if (md == 1) begin
                tgt = d ? 0 : N - 1;
                if (m_idx != tgt) m_idx = m_idx + (d ? -1 : 1);
                m_done = (m_idx == tgt) ? 1 : 0;
            end else begin
                if (m_idx < LS) begin
                    m_rev = 0; m_idx = m_idx + 1;
                end else if (N - 1 == LS) begin
                    m_wrap = 1;
                end else begin
                    nxt = m_idx + (m_rev != 0 ? -1 : 1);
                    if (nxt > N - 1 || nxt < LS) begin
                        m_rev  = (m_rev != 0) ? 0 : 1;
                        nxt    = m_idx + (m_rev != 0 ? -1 : 1);
                        m_wrap = 1;
                    end
                    m_idx = nxt;
                end
            end
        end
    endtask

    initial begin
        int pp[20];
        pp = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 2, 3, 4, 5, 6};
        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'd0; load = 1'b0; load_idx = '0;

        // Reset, then forward cycle with wrap back to LOOP_START
        add(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            add(0, 1, 0, 2'd0, 0, 0, (k <= 8) ? k : k - 8, k == 9, 0, 0);
        // Reverse cycle from idx 0
        add(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 2'd0, 0, 0, 8, 1, 0, 0);
        for (int k = 7; k >= 1; k--) add(0, 1, 1, 2'd0, 0, 0, k, 0, 0, 0);
        add(0, 1, 1, 2'd0, 0, 0, 8, 1, 0, 0);
        // One-shot forward and reverse, done stickiness
        add(0, 0, 0, 2'd1, 1, 5, 5, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 0, 6, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 0, 7, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 0, 8, 0, 1, 0);
        add(0, 1, 0, 2'd1, 0, 0, 8, 0, 1, 0);
        add(0, 1, 1, 2'd1, 0, 0, 8, 0, 1, 0);
        add(0, 0, 0, 2'd1, 1, 2, 2, 0, 0, 0);
        add(0, 1, 1, 2'd1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 2'd1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 2'd1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 2'd0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 2'd0, 1, 4, 4, 0, 0, 0);
        // Out-of-range load, sticky err, load beats en, rst beats everything
        add(0, 1, 0, 2'd0, 1, 12, 4, 0, 0, 1);
        add(0, 1, 0, 2'd0, 0, 0, 5, 0, 0, 1);
        add(0, 1, 0, 2'd0, 1, 3, 3, 0, 0, 1);
        add(0, 0, 0, 2'd0, 0, 0, 3, 0, 0, 1);
        add(1, 1, 0, 2'd0, 1, 5, 0, 0, 0, 0);
        // Ping-pong with random dir, then mode 3 behaves as cycle
        for (int k = 0; k < 20; k++)
            add(0, 1, 1'($urandom_range(0, 1)), 2'd2, 0, 0, pp[k], k == 8 || k == 15, 0, 0);
        add(0, 1, 0, 2'd3, 0, 0, 7, 0, 0, 0);
        add(0, 1, 0, 2'd3, 0, 0, 8, 0, 0, 0);
        add(0, 1, 0, 2'd3, 0, 0, 1, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].load, tbl[i].li);
            @(posedge clk); #1;
            cmp_all($sformatf("vec%0d", i), tbl[i].eidx, tbl[i].ewrap, tbl[i].edone, tbl[i].eerr);
        end

        // Corrupted step vector is recovered to idx 0 with err
        drive(1, 0, 0, 2'd0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 2'd0, 0, 0);
        @(posedge clk); #1;
        cmp_all("pre_corrupt", 3, 0, 0, 0);
        drive(0, 0, 0, 2'd0, 0, 0);
        force dut.r_step = 9'h006;
        #1 release dut.r_step;
        @(posedge clk); #1;
        cmp_all("corrupt_step", 0, 0, 0, 1);

        // Index disagreeing with a valid one-hot step is also recovered
        drive(1, 0, 0, 2'd0, 0, 0);
        drive(0, 1, 0, 2'd0, 0, 0);
        drive(0, 1, 0, 2'd0, 0, 0);
        drive(0, 0, 0, 2'd0, 0, 0);
        force dut.r_idx = 4'd5;
        #1 release dut.r_idx;
        @(posedge clk); #1;
        cmp_all("corrupt_idx", 0, 0, 0, 1);

        // rst mid-run clears err and overrides load/en
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 2'd0, 0, 0);
        @(posedge clk); #1;
        cmp_all("pre_rst", 3, 0, 0, 1);
        drive(1, 1, 0, 2'd0, 1, 5);
        @(posedge clk); #1;
        cmp_all("mid_rst", 0, 0, 0, 0);

        // Randomised traffic against the behavioural model
        model(1, 0, 0, 2'd0, 0, 0);
        drive(1, 0, 0, 2'd0, 0, 0);
        @(posedge clk); #1;
        cmp_all("rand_rst", m_idx, 1'(m_wrap), 1'(m_done), 1'(m_err));
        for (int c = 0; c < 500; c++) begin
            bit       r, e, d, l;
            bit [1:0] m;
            bit [3:0] li;
            r  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 70);
            d  = 1'($urandom_range(0, 1));
            m  = 2'($urandom_range(0, 3));
            l  = ($urandom_range(0, 99) < 10);
            li = 4'($urandom_range(0, 15));
            model(r, e, d, m, l, int'(li));
            drive(r, e, d, m, l, li);
            @(posedge clk); #1;
            cmp_all($sformatf("rand%0d", c), m_idx, 1'(m_wrap), 1'(m_done), 1'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
